// File: rtl/serial_bcd_alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// serial_bcd_alu_sched_pkg
// Shared constants for the serial BCD ALU scheduler: frame layout on the ALU
// serial pins, op encodings, the packed layout of one latched request and the
// FSM state encodings.
// -----------------------------------------------------------------------------
package serial_bcd_alu_sched_pkg;

  localparam int FRAME_BITS = 33;  // A (16) + B (16) + op (1)
  localparam int A_BITS     = 16;
  localparam int B_BITS     = 16;
  localparam int RES_BITS   = 20;  // 5 BCD digits
  localparam int CNT_W      = 6;   // bit counter, covers 0..FRAME_BITS-1

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit 0 of this struct is the first bit sent on alu_in.
  typedef struct packed {
    logic              op;
    logic [B_BITS-1:0] b;
    logic [A_BITS-1:0] a;
  } frame_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

endpackage

// File: rtl/serial_bcd_alu_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Grants the first valid requester found starting at the
// pointer and wrapping upward. On accept_i the pointer moves one past the
// current winner.
// Ports:
//   clk, rst     clock, synchronous active-high reset (pointer -> 0)
//   valid_i      per-requester valid
//   accept_i     strobe: the current grant was taken this cycle
//   grant_o      one-hot grant (all zero when nothing is valid)
//   grant_idx_o  binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // NOTE: every signal written in always_comb gets a default at the top so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!found && valid_i[idx]) begin
        found       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = IW'((int'(grant_idx_o) + 1) % NREQ);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/serial_bcd_alu_sched.sv
// -----------------------------------------------------------------------------
// serial_bcd_alu_sched
// Shares one serial BCD ALU between NREQ parallel requesters. The winner's
// operands are latched, shifted out as a 33-bit frame on alu_en/alu_in, the
// 20-bit result is shifted back in from alu_result and returned on resp_data_o
// with a one-cycle resp_valid_o pulse to the winner.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_a_i/b_i    operands, 16 bits (4 BCD digits) per requester
//   req_op_i       0 = add, 1 = subtract (A-B)
//   req_ready_o    one-hot grant, only in IDLE
//   resp_valid_o   one-cycle pulse to the owner of resp_data_o
//   resp_data_o    5-digit BCD result, held until the next response
//   busy_o         grant cycle through response cycle
//   alu_en_o/in_o  serial frame to the ALU
//   alu_result_i   serial result from the ALU
// Parameters: RES_DLY (en-low to first result bit), GAP (idle cycles after a
// response before the next grant). Both must be below 64.
// -----------------------------------------------------------------------------
module serial_bcd_alu_sched
  import serial_bcd_alu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RES_DLY = 1,
  parameter int GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [16*NREQ-1:0]   req_a_i,
  input  logic [16*NREQ-1:0]   req_b_i,
  input  logic [NREQ-1:0]      req_op_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      resp_valid_o,
  output logic [RES_BITS-1:0]  resp_data_o,
  output logic                 busy_o,
  output logic                 alu_en_o,
  output logic                 alu_in_o,
  input  logic                 alu_result_i
);

  localparam int IW = $clog2(NREQ);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  frame_t              frame_q, frame_d;
  logic [IW-1:0]       win_q, win_d;
  logic [RES_BITS-1:0] shift_q, shift_d;
  logic [RES_BITS-1:0] resp_data_q, resp_data_d;

  logic [NREQ-1:0]     grant;
  logic [IW-1:0]       grant_idx;
  logic                idle;
  logic                handshake;

  assign idle = (state_q == ST_IDLE);

  // Grants are only offered in IDLE; holding them off during rst keeps a
  // transfer from being seen on the reset edge.
  assign req_ready_o = (idle && !rst) ? grant : '0;
  assign handshake   = |(req_ready_o & req_valid_i);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (req_valid_i),
    .accept_i    (handshake),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    win_d       = win_q;
    shift_d     = shift_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          frame_d.a = req_a_i[A_BITS*grant_idx +: A_BITS];
          frame_d.b = req_b_i[B_BITS*grant_idx +: B_BITS];
          frame_d.op = req_op_i[grant_idx];
          win_d     = grant_idx;
          cnt_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          cnt_d   = '0;
          state_d = (RES_DLY == 0) ? ST_RECV : ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(RES_DLY - 1)) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        // Result arrives LSB first: enter at the top so bit 0 ends at bit 0.
        shift_d = {alu_result_i, shift_q[RES_BITS-1:1]};
        if (cnt_q == CNT_W'(RES_BITS - 1)) begin
          cnt_d       = '0;
          resp_data_d = shift_d;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  // NOTE: datapath holding registers are not reset; the FSM never lets their
  // contents reach an output before they have been loaded.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    win_q   <= win_d;
    shift_q <= shift_d;
  end

  assign alu_en_o     = (state_q == ST_SEND);
  assign alu_in_o     = alu_en_o ? frame_q[cnt_q] : 1'b0;
  assign resp_valid_o = (state_q == ST_RESP) ? (NREQ'(1) << win_q) : '0;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = handshake || (state_q == ST_SEND) || (state_q == ST_WAIT) ||
                        (state_q == ST_RECV) || (state_q == ST_RESP);

endmodule

// File: tb/tb_serial_bcd_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_serial_bcd_alu_sched
// Directed bench for serial_bcd_alu_sched. Two instances: the default build
// (RES_DLY=1, GAP=2) and a RES_DLY=3, GAP=0 build, each wired to its own
// behavioural serial BCD ALU.
// -----------------------------------------------------------------------------
module tb_serial_bcd_alu_sched;
  import serial_bcd_alu_sched_pkg::*;

  localparam int RD0 = 1, GAP0 = 2;
  localparam int RD1 = 3, GAP1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  req_valid0 = '0, req_op0 = '0;
  logic [31:0] req_a0 = '0, req_b0 = '0;
  logic [1:0]  req_ready0, resp_valid0;
  logic [19:0] resp_data0;
  logic        busy0, alu_en0, alu_in0;

  logic [1:0]  req_valid1 = '0, req_op1 = '0;
  logic [31:0] req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_ready1, resp_valid1;
  logic [19:0] resp_data1;
  logic        busy1, alu_en1, alu_in1;

  logic [1:0]  alu_res_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_bcd_alu_sched #(.NREQ(2), .RES_DLY(RD0), .GAP(GAP0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid0), .req_a_i(req_a0), .req_b_i(req_b0), .req_op_i(req_op0),
    .req_ready_o(req_ready0), .resp_valid_o(resp_valid0), .resp_data_o(resp_data0),
    .busy_o(busy0), .alu_en_o(alu_en0), .alu_in_o(alu_in0), .alu_result_i(alu_res_w[0])
  );

  serial_bcd_alu_sched #(.NREQ(2), .RES_DLY(RD1), .GAP(GAP1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid1), .req_a_i(req_a1), .req_b_i(req_b1), .req_op_i(req_op1),
    .req_ready_o(req_ready1), .resp_valid_o(resp_valid1), .resp_data_o(resp_data1),
    .busy_o(busy1), .alu_en_o(alu_en1), .alu_in_o(alu_in1), .alu_result_i(alu_res_w[1])
  );

  // ---------------- behavioural serial BCD ALU (one per instance) -----------
  function automatic int bcd2int(input logic [15:0] x);
    int v = 0;
    for (int d = 3; d >= 0; d--) v = v * 10 + int'(x[4*d +: 4]);
    return v;
  endfunction

  function automatic logic [19:0] alu_calc(input logic [32:0] f);
    int a, b, r;
    logic [19:0] o;
    a = bcd2int(f[15:0]);
    b = bcd2int(f[31:16]);
    r = (f[32] == OP_SUB) ? (a - b + 100000) % 100000 : a + b;
    o = '0;
    for (int d = 0; d < 5; d++) begin
      o[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return o;
  endfunction

  function automatic logic out_bit(input logic [19:0] res, input int rel, input int rd);
    if (rel >= rd && rel < rd + 20) return res[rel - rd];
    return 1'b0;
  endfunction

  wire [1:0] m_en = {alu_en1, alu_en0};
  wire [1:0] m_in = {alu_in1, alu_in0};
  logic [32:0] m_frame [2];
  logic [19:0] m_res   [2];
  int          m_nbits [2];
  int          m_rel   [2];  // position of the next cycle relative to E, -1 idle

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_nbits[g]   <= 0;
        m_rel[g]     <= -1;
        alu_res_w[g] <= 1'b0;
      end else if (m_en[g]) begin
        m_frame[g] <= {m_in[g], m_frame[g][32:1]};
        m_nbits[g] <= m_nbits[g] + 1;
        if (m_nbits[g] == FRAME_BITS - 1) begin
          m_res[g]     <= alu_calc({m_in[g], m_frame[g][32:1]});
          m_rel[g]     <= 0;
          alu_res_w[g] <= out_bit(alu_calc({m_in[g], m_frame[g][32:1]}), 0, (g == 0) ? RD0 : RD1);
        end
      end else begin
        m_nbits[g] <= 0;
        if (m_rel[g] >= 0) begin
          m_rel[g]     <= (m_rel[g] + 1 >= ((g == 0) ? RD0 : RD1) + 20) ? -1 : m_rel[g] + 1;
          alu_res_w[g] <= out_bit(m_res[g], m_rel[g] + 1, (g == 0) ? RD0 : RD1);
        end else begin
          alu_res_w[g] <= 1'b0;
        end
      end
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Called at +2 of a cycle; returns at +3 of the first cycle with a grant
  // (or after 20 cycles). waited counts cycles advanced.
  task automatic wait_ready(input int sel, output int waited);
    waited = 0;
    #1;
    while (((sel == 0) ? req_ready0 : req_ready1) == 2'b00 && waited < 20) begin
      cyc();
      #1;
      waited++;
    end
  endtask

  // Observes one frame starting the cycle after the handshake, up to and
  // including the response cycle (bounded at 100 cycles).
  task automatic run_frame(input int sel, input bit drop, input int raise_at,
                           input logic [1:0] raise_mask,
                           output int en_cnt, output int first_en, output logic [32:0] bits,
                           output int resp_at, output logic [1:0] resp_v,
                           output logic [19:0] data, output bit side_err);
    int last_en;
    logic en, din;
    en_cnt = 0; first_en = -1; last_en = -1; bits = '0;
    resp_at = -1; resp_v = '0; data = '0; side_err = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (i == 1 && drop) begin
        if (sel == 0) req_valid0 = '0; else req_valid1 = '0;
      end
      if (i == raise_at) begin
        if (sel == 0) req_valid0 = req_valid0 | raise_mask;
        else          req_valid1 = req_valid1 | raise_mask;
      end
      #1;
      en  = (sel == 0) ? alu_en0 : alu_en1;
      din = (sel == 0) ? alu_in0 : alu_in1;
      if (en) begin
        if (first_en < 0) first_en = i;
        else if (last_en != i - 1) side_err = 1'b1;
        last_en = i;
        if (en_cnt < 33) bits[en_cnt] = din;
        en_cnt++;
      end else if (din) begin
        side_err = 1'b1;
      end
      if (((sel == 0) ? req_ready0 : req_ready1) != 2'b00) side_err = 1'b1;
      if (!((sel == 0) ? busy0 : busy1)) side_err = 1'b1;
      if (((sel == 0) ? resp_valid0 : resp_valid1) != 2'b00) begin
        resp_at = i;
        resp_v  = (sel == 0) ? resp_valid0 : resp_valid1;
        data    = (sel == 0) ? resp_data0 : resp_data1;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int en_cnt, first_en, resp_at, waited, stray;
    logic [32:0] bits;
    logic [1:0]  resp_v;
    logic [19:0] data;
    bit          side_err;

    // Reset
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_ready",  req_ready0,  2'b00);
    check("rst_rvalid", resp_valid0, 2'b00);
    check("rst_rdata",  resp_data0,  20'h0);
    check("rst_busy",   busy0,       1'b0);
    check("rst_en",     alu_en0,     1'b0);
    check("rst_in",     alu_in0,     1'b0);

    // 1) requester 0: 1234 + 5678
    cyc();
    req_a0 = {16'h0000, 16'h1234}; req_b0 = {16'h0000, 16'h5678}; req_op0 = 2'b00;
    req_valid0 = 2'b01;
    wait_ready(0, waited);
    check("t1_ready", req_ready0, 2'b01);
    check("t1_busy_grant", busy0, 1'b1);
    run_frame(0, 1'b1, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t1_en_first", first_en, 1);
    check("t1_en_cnt",   en_cnt,   33);
    check("t1_frame",    bits,     {OP_ADD, 16'h5678, 16'h1234});
    check("t1_resp_at",  resp_at,  55);
    check("t1_resp_v",   resp_v,   2'b01);
    check("t1_data",     data,     20'h06912);
    check("t1_side",     side_err, 1'b0);

    // 2) requester 1: 5000 - 1234
    req_a0 = {16'h5000, 16'h0000}; req_b0 = {16'h1234, 16'h0000}; req_op0 = 2'b10;
    req_valid0 = 2'b10;
    wait_ready(0, waited);
    check("t2_wait",  waited, 3);
    check("t2_ready", req_ready0, 2'b10);
    check("t2_hold",  resp_data0, 20'h06912);
    run_frame(0, 1'b1, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t2_frame",   bits,     {OP_SUB, 16'h1234, 16'h5000});
    check("t2_resp_at", resp_at,  55);
    check("t2_resp_v",  resp_v,   2'b10);
    check("t2_data",    data,     20'h03766);
    check("t2_side",    side_err, 1'b0);

    // 3) both valid continuously: grants alternate 0,1,0,1
    req_a0 = {16'h9999, 16'h0001}; req_b0 = {16'h0001, 16'h0002}; req_op0 = 2'b00;
    req_valid0 = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ready(0, waited);
      check("t3_wait",  waited, 3);
      check("t3_ready", req_ready0, (f % 2 == 0) ? 2'b01 : 2'b10);
      run_frame(0, 1'b0, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
      check("t3_resp_v", resp_v, (f % 2 == 0) ? 2'b01 : 2'b10);
      check("t3_data",   data,   (f % 2 == 0) ? 20'h00003 : 20'h10000);
      check("t3_side",   side_err, 1'b0);
    end

    // 4) requester 1 raises valid during SEND of requester 0's frame
    req_a0 = {16'h0100, 16'h0042}; req_b0 = {16'h0099, 16'h0013}; req_op0 = 2'b10;
    req_valid0 = 2'b01;
    wait_ready(0, waited);
    check("t4_wait",  waited, 3);
    check("t4_ready", req_ready0, 2'b01);
    run_frame(0, 1'b1, 10, 2'b10, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t4_resp_v", resp_v,   2'b01);
    check("t4_data",   data,     20'h00055);
    check("t4_side",   side_err, 1'b0);
    wait_ready(0, waited);
    check("t4_wait2",  waited, 3);
    check("t4_ready2", req_ready0, 2'b10);
    run_frame(0, 1'b1, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t4_resp_v2", resp_v, 2'b10);
    check("t4_data2",   data,   20'h00001);

    // 5) rst pulsed in the 10th SEND cycle aborts the frame
    req_a0 = {16'h0000, 16'h7777}; req_b0 = {16'h0000, 16'h1111}; req_op0 = 2'b00;
    req_valid0 = 2'b01;
    wait_ready(0, waited);
    check("t5_ready", req_ready0, 2'b01);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 1) req_valid0 = '0;
    end
    #1;
    check("t5_en_before", alu_en0, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t5_en_after",   alu_en0,     1'b0);
    check("t5_busy_after", busy0,       1'b0);
    check("t5_rv_after",   resp_valid0, 2'b00);
    stray = 0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      #1;
      if (resp_valid0 != 2'b00 || alu_en0) stray++;
    end
    check("t5_no_resp", stray, 0);
    req_a0 = {16'h0000, 16'h0001}; req_b0 = {16'h0000, 16'h0001}; req_op0 = 2'b00;
    req_valid0 = 2'b01;
    wait_ready(0, waited);
    check("t5_ready2", req_ready0, 2'b01);
    run_frame(0, 1'b1, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t5_resp_at", resp_at, 55);
    check("t5_resp_v",  resp_v,  2'b01);
    check("t5_data",    data,    20'h00002);

    // 6) RES_DLY=3, GAP=0 build
    req_a1 = {16'h1111, 16'h0500}; req_b1 = {16'h2222, 16'h0499}; req_op1 = 2'b01;
    req_valid1 = 2'b11;
    wait_ready(1, waited);
    check("t6_ready", req_ready1, 2'b01);
    run_frame(1, 1'b0, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t6_en_cnt",  en_cnt,  33);
    check("t6_frame",   bits,    {OP_SUB, 16'h0499, 16'h0500});
    check("t6_resp_at", resp_at, 57);
    check("t6_resp_v",  resp_v,  2'b01);
    check("t6_data",    data,    20'h00001);
    check("t6_side",    side_err, 1'b0);
    wait_ready(1, waited);
    check("t6_wait",  waited, 1);
    check("t6_ready2", req_ready1, 2'b10);
    run_frame(1, 1'b1, 0, 2'b00, en_cnt, first_en, bits, resp_at, resp_v, data, side_err);
    check("t6_resp_at2", resp_at, 57);
    check("t6_resp_v2",  resp_v,  2'b10);
    check("t6_data2",    data,    20'h03333);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_bcd_alu_sched.md
Name: serial_bcd_alu_sched

Overview:
Round-robin scheduler that shares one serial_bcd_alu between NREQ parallel requesters. Each requester presents two 4-digit packed-BCD operands and an op bit. The block serialises them onto the ALU's en/in pins, deserialises the 20-bit (5-digit) serial result, and returns it to the winning requester. It sits between the parallel front-end logic and the single serial ALU instance; the ALU shares clk and rst.

Parameters:
NREQ, 2, number of requesters (2..4)
RES_DLY, 1, cycles from the first en-low cycle to the first result bit on alu_result
GAP, 2, minimum idle cycles between the end of one ALU frame and the next grant

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_a  in  16*NREQ  operand A, 4 packed BCD digits, slice i = requester i
req_b  in  16*NREQ  operand B, same packing
req_op  in  NREQ  0 = add, 1 = subtract (A-B)
req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
resp_valid  out  NREQ  one-cycle pulse to the requester owning resp_data
resp_data  out  20  5-digit BCD result, shared bus
busy  out  1  high from the grant cycle through the response cycle
alu_en  out  1  to ALU en
alu_in  out  1  to ALU in
alu_result  in  1  from ALU result

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, busy=0, alu_en=0, alu_in=0. Round-robin pointer points at requester 0. FSM is in IDLE.
- ALU frame contract, fixed: alu_en high for exactly 33 consecutive cycles.
  - Bits 0-15: A, LSB first (digit 0 bit 0 first).
  - Bits 16-31: B, LSB first.
  - Bit 32: op.
  - Result bit k (LSB first, k=0..19) is sampled on alu_result in cycle E+RES_DLY+k, where E is the first cycle with alu_en=0.
  - alu_in is 0 whenever alu_en=0.
- FSM states: IDLE, SEND, WAIT, RECV, RESP, GAP.
- IDLE: combinationally assert req_ready for the highest-priority valid requester. Priority starts at the pointer and wraps upward.
  - No valid requester: req_ready=0.
  - Handshake at cycle T: latch A/B/op and the winner index. Pointer moves to winner+1 mod NREQ. Go to SEND.
- SEND: cycles T+1..T+33, alu_en=1, alu_in = frame bit (cycle-T-1). A 6-bit counter drives the bit index. Go to WAIT.
- WAIT: RES_DLY cycles with alu_en=0. With RES_DLY=0, skip WAIT.
- RECV: 20 cycles. Shift alu_result into bit 19 of a 20-bit shift register, so the LSB ends in bit 0.
- RESP: one cycle. resp_valid[winner]=1, resp_data = assembled value. resp_data holds until the next RESP. Go to GAP.
- GAP: GAP idle cycles, then IDLE. With GAP=0, go straight to IDLE.
- Latency: handshake at T gives resp_valid at T+54+RES_DLY. Next earliest handshake is at T+55+RES_DLY+GAP.
- One frame outstanding at a time. req_valid dropping after the handshake has no effect. The operand inputs are not re-read after the handshake.
- Requests with valid raised outside IDLE wait. Requesters must hold req_valid; there is no queueing in this block.
- Simultaneous requests: the pointer decides the winner. Requesters that keep req_valid high are served strictly alternately (NREQ=2).
- Operands are passed unchecked. Non-BCD nibbles go to the ALU as-is.
- rst asserted in any state: all outputs take reset values on that edge and the pointer returns to 0. The aborted frame produces no response. An in-flight ALU frame ends because alu_en drops and the ALU is reset too.

Decomposition:
- Shared package/include holds: FRAME_BITS=33, A_BITS=16, B_BITS=16, RES_BITS=20, OP_ADD=0, OP_SUB=1, and the FSM state encodings.
- One sub-module is natural: rr_arbiter (NREQ valid in, one-hot grant out, pointer update on an accept strobe). The FSM, serialiser mux, bit counter and result shift register stay in the top module.

Test Plan:
- Reset, then req_valid[0] with A=1234, B=5678, op=0 against an ALU model:
  - alu_en high for exactly 33 cycles.
  - alu_in sequence 0,0,1,0,1,1,0,0,... (0x1234 LSB first), then 0x5678 LSB first, then 0.
  - resp_valid[0] at T+55, resp_data=0x06912.
- req_valid[1] with A=5000, B=1234, op=1: op bit in frame = 1, resp_valid[1] only, resp_data=0x03766.
- Both requesters valid continuously, 4 frames: grants go 0,1,0,1. Gap between resp_valid and the next handshake is exactly GAP+1 cycles. No double grant.
- Request raised mid-SEND by the other requester: not granted until IDLE, then served next. The first response is unaffected.
- rst pulsed for 1 cycle at the 10th SEND cycle: alu_en=0 and busy=0 on the next cycle, no resp_valid. A fresh request A=0001, B=0001 then returns 0x00002.
- RES_DLY=3, GAP=0 build: resp_valid at T+57. Back-to-back handshake one cycle after RESP.
